// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared definitions for the multiply/divide unit: operation encodings,
//   FSM state encoding, default latencies and small decode helpers.
package mips_pkg;

  // Encoding of the op field presented together with an MDU start pulse.
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // Default busy-cycle counts for the two operation classes.
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  // Bit 1 of the encoding separates divides from multiplies.
  function automatic logic is_div(input mdu_op_e op);
    return op[1];
  endfunction

  // Bit 0 clear means a signed (mult/div) operation.
  function automatic logic is_signed_op(input mdu_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith
//   Purely combinational arithmetic for the MDU. Produces the HI/LO pair for
//   the selected operation from already-latched operands.
//   Ports:
//     op     [1:0]  in   operation (mult, multu, div, divu)
//     a      [31:0] in   rs operand (dividend / multiplicand)
//     b      [31:0] in   rt operand (divisor / multiplier)
//     hi_res [31:0] out  upper product word, or remainder
//     lo_res [31:0] out  lower product word, or quotient
module mdu_arith
  import mips_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res
);

  mdu_op_e     op_e;
  logic        sgn;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_res;
  logic [31:0] r_res;

  always_comb begin
    op_e = mdu_op_e'(op);
    sgn  = is_signed_op(op_e);

    // Low 64 bits of an unsigned product of sign-extended operands are the
    // two's-complement signed product.
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide via magnitudes: quotient truncates toward zero and the
    // remainder follows the dividend. 0x80000000 / -1 falls out naturally as
    // 0x80000000 rem 0 because the negation wraps.
    a_neg  = sgn & a[31];
    b_neg  = sgn & b[31];
    a_mag  = a_neg ? (~a + 32'd1) : a;
    b_mag  = b_neg ? (~b + 32'd1) : b;
    b_safe = (b == '0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    q_res  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    r_res  = a_neg ? (~r_mag + 32'd1) : r_mag;

    hi_res = '0;
    lo_res = '0;
    case (op_e)
      OP_MULT:  {hi_res, lo_res} = prod_s;
      OP_MULTU: {hi_res, lo_res} = prod_u;
      OP_DIV, OP_DIVU: begin
        if (b == '0) begin
          lo_res = '1;
          hi_res = a;
        end else begin
          lo_res = q_res;
          hi_res = r_res;
        end
      end
      default: begin
        hi_res = '0;
        lo_res = '0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl
//   Multi-cycle MIPS multiply/divide control: IDLE/RUN FSM, busy down-counter,
//   operand capture and the architectural HI/LO registers. The arithmetic
//   itself lives in mdu_arith and works on the captured operands, so the
//   E-stage operand buses may change freely while an operation runs.
//   Ports:
//     clk, rst_n          clock, synchronous active-low reset
//     start, op, a, b     E-stage issue of mult/multu/div/divu
//     hilo_we, hilo_sel,  mthi/mtlo write (sel 1 = HI, 0 = LO)
//     wdata
//     use_hiloD           D-stage instruction touches HI/LO or the MDU
//     busy                operation in progress
//     stall_req           stall F/D and flush E (to hazard unit)
//     hi, lo              HI/LO register contents
module mdu_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hilo_we,
  input  logic        hilo_sel,
  input  logic [31:0] wdata,
  input  logic        use_hiloD,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  // Counter only ever holds N-1, so clog2(N) bits suffice.
  localparam int unsigned CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      hi_res;
  logic [31:0]      lo_res;

  mdu_arith u_arith (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .hi_res (hi_res),
    .lo_res (lo_res)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      ST_IDLE: begin
        // An mthi/mtlo in the same cycle as a start still lands; the
        // operation result overwrites it when it completes.
        if (hilo_we) begin
          if (hilo_sel) hi_d = wdata;
          else          lo_d = wdata;
        end
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          cnt_d   = is_div(mdu_op_e'(op)) ? DIV_LOAD : MULT_LOAD;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // start and hilo_we are deliberately ignored while running.
        if (cnt_q == '0) begin
          hi_d    = hi_res;
          lo_d    = lo_res;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign stall_req = use_hiloD & (busy | start);
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, number of busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, number of busy cycles for div/divu.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  E-stage mult/multu/div/divu issue, one-cycle pulse.
REQ-006 op  input  2  00 mult, 01 multu, 10 div, 11 divu, sampled with start.
REQ-007 a  input  32  rs operand (forwarded E-stage value), sampled with start.
REQ-008 b  input  32  rt operand (forwarded E-stage value), sampled with start.
REQ-009 hilo_we  input  1  mthi/mtlo write enable (E stage).
REQ-010 hilo_sel  input  1  0 selects LO, 1 selects HI for hilo_we.
REQ-011 wdata  input  32  mthi/mtlo write data.
REQ-012 use_hiloD  input  1  D-stage instruction is mfhi/mflo/mthi/mtlo/mult/multu/div/divu.
REQ-013 busy  output  1  operation in progress.
REQ-014 stall_req  output  1  request to stall F/D and flush E, to the hazard unit.
REQ-015 hi  output  32  HI register.
REQ-016 lo  output  32  LO register.

Function
REQ-017 SHALL implement FSM with states IDLE and RUN; busy = (state==RUN), registered.
REQ-018 IDLE + start: SHALL latch op/a/b, load down-counter with N-1 (N = MULT_CYCLES or DIV_CYCLES per op), go to RUN.
REQ-019 RUN: SHALL decrement counter each cycle; at counter==0 SHALL write HI/LO on that edge and return to IDLE.
REQ-020 busy SHALL be high for exactly N cycles following the start edge; hi/lo change on the same edge busy falls.
REQ-021 start while RUN SHALL be ignored (no relatch, no restart).
REQ-022 mult: {HI,LO} = signed 64-bit a*b; multu: unsigned 64-bit product.
REQ-023 div: LO = quotient truncated toward zero, HI = remainder with sign of dividend; divu: unsigned quotient/remainder.
REQ-024 Divide by zero (b==0) SHALL give LO = 32'hFFFFFFFF, HI = a, for div and divu.
REQ-025 div of 32'h80000000 by 32'hFFFFFFFF SHALL give LO = 32'h80000000, HI = 0.
REQ-026 hilo_we in IDLE SHALL write wdata to selected register next edge; hilo_we during RUN SHALL be ignored.
REQ-027 hilo_we and start in same IDLE cycle: write SHALL take effect, later overwritten by the operation result.
REQ-028 stall_req SHALL equal use_hiloD && (busy || start), combinational.
REQ-029 Operands SHALL be held internally; a/b changes during RUN SHALL not affect the result.

Reset
REQ-030 rst_n low at a rising edge SHALL force state IDLE, counter 0, busy 0, hi 0, lo 0.
REQ-031 Reset during RUN SHALL abort the operation with no HI/LO write.
REQ-032 stall_req SHALL be 0 in reset when start is 0.

Structure
REQ-033 Op encodings and default MULT_CYCLES/DIV_CYCLES SHALL live in shared package mips_pkg.
REQ-034 Arithmetic SHALL be in one combinational sub-module mdu_arith (op, a, b -> hi_res, lo_res); FSM, counter, HI/LO in mdu_ctrl.

Verification
REQ-035 mult a=32'hFFFFFFFE (-2), b=3 -> busy 5 cycles, then HI=32'hFFFFFFFF, LO=32'hFFFFFFFA.
REQ-036 divu a=100, b=7 -> busy 10 cycles, then LO=14, HI=2; div a=-7, b=2 -> LO=-3, HI=-1.
REQ-037 div a=5, b=0 -> LO=32'hFFFFFFFF, HI=5; div 32'h80000000 / -1 -> LO=32'h80000000, HI=0.
REQ-038 start with use_hiloD=1 -> stall_req high on start cycle and all 5 busy cycles, low after; second start during RUN ignored.
REQ-039 mtlo wdata=32'h1234 in IDLE -> lo=32'h1234 next cycle; mthi during RUN -> hi unchanged.
REQ-040 rst_n low at busy cycle 3 of multu -> busy 0, hi=lo=0 next cycle, no later result write.
